// File: rtl/axi_addr_decode_route.sv
// -----------------------------------------------------------------------------
// axi_addr_decode_route
//
// Request-side address decoder for one slave port / one address channel
// (AR or AW) of the AXI node. It compares the request address against the
// address rules produced by the node's configuration register block and
// turns the winning rule into a one-hot master-port select. Requests that
// match no rule are not forwarded. Instead they are answered locally with a
// DECERR response burst of len+1 beats.
//
// The block handles one request at a time. A new request is accepted only
// in IDLE, so two accepts are always at least 2 cycles apart.
//
// Optional feature (macro AXI_DECODE_ERR_CNT_EN):
//   When defined, the block adds err_cnt_o. This is a 16-bit saturating
//   count of requests sent to ERR, counted at acceptance.
//
// Ports:
//   s_axi_aclk, s_axi_aresetn   clock and asynchronous active-low reset
//   req_*                       incoming request (addr/id/len, valid/ready)
//   START_ADDR_i, END_ADDR_i    flattened rule bounds, entry r*N_MASTER_PORT+m
//   valid_rule_i                rule enables, same indexing
//   connectivity_i              this slave's row of the connectivity map
//   route_*                     decoded request towards the master arbiter
//   err_*                       locally generated DECERR response beats
//   err_cnt_o                   (optional) count of requests sent to ERR
// -----------------------------------------------------------------------------
module axi_addr_decode_route #(
  parameter int ADDR_WIDTH    = 32,
  parameter int N_REGION_MAX  = 4,
  parameter int N_MASTER_PORT = 16,
  parameter int ID_WIDTH      = 4,
  parameter int LEN_WIDTH     = 8
) (
  input  logic                                        s_axi_aclk,
  input  logic                                        s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]                       req_addr_i,
  input  logic [ID_WIDTH-1:0]                         req_id_i,
  input  logic [LEN_WIDTH-1:0]                        req_len_i,
  input  logic                                        req_valid_i,
  output logic                                        req_ready_o,
  input  logic [N_REGION_MAX*N_MASTER_PORT*ADDR_WIDTH-1:0] START_ADDR_i,
  input  logic [N_REGION_MAX*N_MASTER_PORT*ADDR_WIDTH-1:0] END_ADDR_i,
  input  logic [N_REGION_MAX*N_MASTER_PORT-1:0]       valid_rule_i,
  input  logic [N_MASTER_PORT-1:0]                    connectivity_i,
  output logic                                        route_valid_o,
  input  logic                                        route_ready_i,
  output logic [N_MASTER_PORT-1:0]                    route_sel_o,
  output logic [ADDR_WIDTH-1:0]                       route_addr_o,
  output logic [ID_WIDTH-1:0]                         route_id_o,
  output logic [LEN_WIDTH-1:0]                        route_len_o,
  output logic                                        err_valid_o,
  input  logic                                        err_ready_i,
  output logic [ID_WIDTH-1:0]                         err_id_o,
  output logic [1:0]                                  err_resp_o,
  output logic                                        err_last_o
`ifdef AXI_DECODE_ERR_CNT_EN
  ,
  output logic [15:0]                                 err_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    ERR   = 2'd2
  } state_t;

  localparam logic [1:0] RESP_DECERR = 2'b11;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [N_MASTER_PORT-1:0] r_sel;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [ID_WIDTH-1:0]      r_id;
  logic [LEN_WIDTH-1:0]     r_len;
  logic [LEN_WIDTH-1:0]     r_cnt;

  logic [N_MASTER_PORT-1:0] w_hit;
  logic [N_MASTER_PORT-1:0] w_sel;
  logic                     w_any_hit;
  logic                     w_accept;
  logic                     w_err_hs;

  // ---------------------------------------------------------------------------
  // Rule decode. A master counts as hit when any of its enabled regions
  // contains the address and the master is reachable from this slave.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first. If it
    // had none, some path would leave it unassigned and a latch would be inferred.
    w_hit = '0;
    for (int m = 0; m < N_MASTER_PORT; m++) begin
      for (int r = 0; r < N_REGION_MAX; r++) begin
        if (valid_rule_i[r*N_MASTER_PORT+m] && connectivity_i[m] &&
            (req_addr_i >= START_ADDR_i[(r*N_MASTER_PORT+m)*ADDR_WIDTH +: ADDR_WIDTH]) &&
            (req_addr_i <= END_ADDR_i[(r*N_MASTER_PORT+m)*ADDR_WIDTH +: ADDR_WIDTH])) begin
          w_hit[m] = 1'b1;
        end
      end
    end
  end

  // x & -x keeps only the lowest set bit. That bit is the lowest-numbered
  // master that hit, which gives the priority winner as a one-hot vector.
  assign w_sel     = w_hit & (~w_hit + {{(N_MASTER_PORT-1){1'b0}}, 1'b1});
  assign w_any_hit = |w_hit;

  assign w_accept  = (r_state == IDLE) && req_valid_i;
  assign w_err_hs  = (r_state == ERR) && err_ready_i;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    // NOTE: sequential state uses non-blocking (<=) assignments. All flops
    // then update together at the edge, with no ordering race between blocks.
    if (!s_axi_aresetn) r_state <= IDLE;
    else                r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid_i)  w_state_nxt = w_any_hit ? ROUTE : ERR;
      ROUTE:   if (route_ready_i) w_state_nxt = IDLE;
      ERR:     if (err_ready_i && (r_cnt == '0)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture and beat counter. The select and attributes are frozen at
  // acceptance, so rule rewrites during ROUTE cannot disturb a held request.
  // ---------------------------------------------------------------------------
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_sel  <= '0;
      r_addr <= '0;
      r_id   <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_sel  <= w_sel;
        r_addr <= req_addr_i;
        r_id   <= req_id_i;
        r_len  <= req_len_i;
        if (!w_any_hit) r_cnt <= req_len_i;
      end else if (w_err_hs && (r_cnt != '0)) begin
        r_cnt <= r_cnt - LEN_WIDTH'(1);
      end
    end
  end

`ifdef AXI_DECODE_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_err_cnt <= '0;
    end else if (w_accept && !w_any_hit && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt_o = r_err_cnt;
`endif

  // ---------------------------------------------------------------------------
  // Outputs. The valids are decoded from the state. Only one state can be
  // active, so route_valid_o and err_valid_o are never high together.
  // ---------------------------------------------------------------------------
  assign req_ready_o   = (r_state == IDLE);
  assign route_valid_o = (r_state == ROUTE);
  assign route_sel_o   = r_sel;
  assign route_addr_o  = r_addr;
  assign route_id_o    = r_id;
  assign route_len_o   = r_len;

  assign err_valid_o   = (r_state == ERR);
  assign err_id_o      = r_id;
  assign err_resp_o    = RESP_DECERR;
  assign err_last_o    = (r_state == ERR) && (r_cnt == '0);

endmodule

// File: tb/tb_axi_addr_decode_route.sv
// -----------------------------------------------------------------------------
// tb_axi_addr_decode_route
//
// Directed and randomized bench for axi_addr_decode_route. The bench keeps
// the address rules as 2-D arrays and derives every expected select from a
// plain search over those arrays: the lowest connected master that has an
// enabled region containing the address wins. It also models the DECERR
// burst as a beat count, and the optional error counter as a saturating
// integer.
// -----------------------------------------------------------------------------
module tb_axi_addr_decode_route;

  localparam int AW = 32;
  localparam int NR = 4;
  localparam int NM = 16;
  localparam int IW = 4;
  localparam int LW = 8;

  logic              clk;
  logic              rst_n;
  logic [AW-1:0]     req_addr_i;
  logic [IW-1:0]     req_id_i;
  logic [LW-1:0]     req_len_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [NR*NM*AW-1:0] start_addr;
  logic [NR*NM*AW-1:0] end_addr;
  logic [NR*NM-1:0]  valid_rule;
  logic [NM-1:0]     conn;
  logic              route_valid_o;
  logic              route_ready_i;
  logic [NM-1:0]     route_sel_o;
  logic [AW-1:0]     route_addr_o;
  logic [IW-1:0]     route_id_o;
  logic [LW-1:0]     route_len_o;
  logic              err_valid_o;
  logic              err_ready_i;
  logic [IW-1:0]     err_id_o;
  logic [1:0]        err_resp_o;
  logic              err_last_o;
`ifdef AXI_DECODE_ERR_CNT_EN
  logic [15:0]       err_cnt_o;
`endif

  // Rule table as seen by the reference model.
  logic [AW-1:0] st [NR][NM];
  logic [AW-1:0] ea [NR][NM];
  logic          rule_en [NR][NM];

  int total = 0;
  int bad   = 0;
  int exp_err_cnt = 0;

  axi_addr_decode_route #(
    .ADDR_WIDTH(AW), .N_REGION_MAX(NR), .N_MASTER_PORT(NM),
    .ID_WIDTH(IW), .LEN_WIDTH(LW)
  ) dut (
    .s_axi_aclk     (clk),
    .s_axi_aresetn  (rst_n),
    .req_addr_i     (req_addr_i),
    .req_id_i       (req_id_i),
    .req_len_i      (req_len_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .START_ADDR_i   (start_addr),
    .END_ADDR_i     (end_addr),
    .valid_rule_i   (valid_rule),
    .connectivity_i (conn),
    .route_valid_o  (route_valid_o),
    .route_ready_i  (route_ready_i),
    .route_sel_o    (route_sel_o),
    .route_addr_o   (route_addr_o),
    .route_id_o     (route_id_o),
    .route_len_o    (route_len_o),
    .err_valid_o    (err_valid_o),
    .err_ready_i    (err_ready_i),
    .err_id_o       (err_id_o),
    .err_resp_o     (err_resp_o),
    .err_last_o     (err_last_o)
`ifdef AXI_DECODE_ERR_CNT_EN
    ,
    .err_cnt_o      (err_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Flatten the rule table onto the DUT buses.
  always_comb begin
    start_addr = '0;
    end_addr   = '0;
    valid_rule = '0;
    for (int r = 0; r < NR; r++) begin
      for (int m = 0; m < NM; m++) begin
        start_addr[(r*NM+m)*AW +: AW] = st[r][m];
        end_addr[(r*NM+m)*AW +: AW]   = ea[r][m];
        valid_rule[r*NM+m]            = rule_en[r][m];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decode: the lowest connected master that has any enabled
  // region containing the address wins. No match gives 0.
  function automatic logic [NM-1:0] ref_route(input logic [AW-1:0] a);
    for (int m = 0; m < NM; m++) begin
      if (conn[m]) begin
        for (int r = 0; r < NR; r++) begin
          if (rule_en[r][m] && (a >= st[r][m]) && (a <= ea[r][m]))
            return NM'(1) << m;
        end
      end
    end
    return '0;
  endfunction

  task automatic clear_rules();
    for (int r = 0; r < NR; r++)
      for (int m = 0; m < NM; m++) begin
        st[r][m] = '0; ea[r][m] = '0; rule_en[r][m] = 1'b0;
      end
    conn = '0;
  endtask

  task automatic setup_base();
    clear_rules();
    st[0][2] = 32'h1000_0000;
    ea[0][2] = 32'h1000_FFFF;
    rule_en[0][2] = 1'b1;
    conn = 16'hFFFF;
  endtask

  task automatic randomize_rules();
    for (int r = 0; r < NR; r++)
      for (int m = 0; m < NM; m++) begin
        st[r][m] = ($urandom & 32'hF000_0000) | ($urandom & 32'h00FF_0000);
        ea[r][m] = st[r][m] + $urandom_range(0, 32'h0010_0000);
        if (ea[r][m] < st[r][m]) ea[r][m] = 32'hFFFF_FFFF;
        rule_en[r][m] = ($urandom_range(0, 3) == 0);
      end
    conn = 16'($urandom);
  endtask

  // emode: 0 = err_ready toggles 1/0, 1 = random, 2 = always ready.
  task automatic send_req(input logic [AW-1:0] a, input logic [IW-1:0] id,
                          input logic [LW-1:0] len, input int stall,
                          input int emode, input bit scramble);
    logic [NM-1:0] exp_sel;
    logic          rdy;
    int            beat;
    int            cyc;
    exp_sel = ref_route(a);
    @(negedge clk);
    req_addr_i  = a;
    req_id_i    = id;
    req_len_i   = len;
    req_valid_i = 1'b1;
    check("req_ready_idle", req_ready_o, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    if (exp_sel != '0) begin
      check("route_valid", route_valid_o, 1);
      check("route_err_valid_low", err_valid_o, 0);
      check("route_sel", route_sel_o, exp_sel);
      check("route_addr", route_addr_o, a);
      check("route_id", route_id_o, id);
      check("route_len", route_len_o, len);
      check("route_req_ready_low", req_ready_o, 0);
      for (int i = 0; i < stall; i++) begin
        if (scramble) randomize_rules();
        @(posedge clk);
        @(negedge clk);
        check("stall_valid", route_valid_o, 1);
        check("stall_sel", route_sel_o, exp_sel);
        check("stall_addr", route_addr_o, a);
        check("stall_req_ready", req_ready_o, 0);
      end
      route_ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      route_ready_i = 1'b0;
      check("route_done_valid", route_valid_o, 0);
      check("route_done_req_ready", req_ready_o, 1);
    end else begin
      if (exp_err_cnt < 16'hFFFF) exp_err_cnt++;
      beat = 0;
      cyc  = 0;
      while ((beat <= int'(len)) && (cyc < 300)) begin
        case (emode)
          0:       rdy = (cyc % 2 == 0);
          1:       rdy = 1'($urandom_range(0, 1));
          default: rdy = 1'b1;
        endcase
        err_ready_i = rdy;
        check("err_valid", err_valid_o, 1);
        check("err_route_valid_low", route_valid_o, 0);
        check("err_id", err_id_o, id);
        check("err_resp", err_resp_o, 2'b11);
        check("err_last", err_last_o, (beat == int'(len)));
        check("err_req_ready_low", req_ready_o, 0);
        @(posedge clk);
        @(negedge clk);
        if (rdy) beat++;
        cyc++;
      end
      err_ready_i = 1'b0;
      check("err_beat_count", beat, int'(len) + 1);
      check("err_done_valid", err_valid_o, 0);
      check("err_done_req_ready", req_ready_o, 1);
    end
`ifdef AXI_DECODE_ERR_CNT_EN
    check("err_cnt", err_cnt_o, exp_err_cnt);
`endif
  endtask

  initial begin
    logic [AW-1:0] a;
    int rr;
    int mm;
    rst_n         = 1'b0;
    req_addr_i    = '0;
    req_id_i      = '0;
    req_len_i     = '0;
    req_valid_i   = 1'b0;
    route_ready_i = 1'b0;
    err_ready_i   = 1'b0;
    clear_rules();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready_o, 1);
    check("rst_route_valid", route_valid_o, 0);
    check("rst_err_valid", err_valid_o, 0);
    check("rst_err_last", err_last_o, 0);
    check("rst_route_sel", route_sel_o, 0);
    check("rst_route_addr", route_addr_o, 0);
    check("rst_route_id", route_id_o, 0);
    check("rst_route_len", route_len_o, 0);
    check("rst_err_id", err_id_o, 0);
`ifdef AXI_DECODE_ERR_CNT_EN
    check("rst_err_cnt", err_cnt_o, 0);
`endif
    rst_n = 1'b1;

    // Basic route and basic DECERR burst with stalls
    setup_base();
    send_req(32'h1000_0040, 4'd3, 8'd0, 0, 2, 1'b0);
    send_req(32'h2000_0000, 4'd5, 8'd3, 0, 0, 1'b0);

    // Overlapping rules: lowest master wins, then connectivity removes it
    st[2][1] = 32'h0; ea[2][1] = 32'hFF; rule_en[2][1] = 1'b1;
    st[1][6] = 32'h0; ea[1][6] = 32'hFFFF; rule_en[1][6] = 1'b1;
    send_req(32'h0, 4'd1, 8'd2, 1, 2, 1'b0);
    conn[1] = 1'b0;
    send_req(32'h0, 4'd2, 8'd1, 0, 2, 1'b0);
    conn = '0;
    send_req(32'h0, 4'd7, 8'd0, 0, 2, 1'b0);

    // Address boundaries and disabled rule
    setup_base();
    send_req(32'h1000_0000, 4'd4, 8'd0, 0, 2, 1'b0);
    send_req(32'h1000_FFFF, 4'd6, 8'd5, 0, 2, 1'b0);
    send_req(32'h1001_0000, 4'd8, 8'd1, 0, 1, 1'b0);
    send_req(32'h0FFF_FFFF, 4'd9, 8'd0, 0, 2, 1'b0);
    rule_en[0][2] = 1'b0;
    send_req(32'h1000_0040, 4'd10, 8'd0, 0, 2, 1'b0);

    // Long stall while rules are rewritten
    setup_base();
    send_req(32'h1000_1234, 4'd11, 8'd4, 10, 2, 1'b1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      if (i % 8 == 0) randomize_rules();
      rr = $urandom_range(0, NR-1);
      mm = $urandom_range(0, NM-1);
      case ($urandom_range(0, 3))
        0:       a = $urandom;
        1:       a = st[rr][mm];
        2:       a = ea[rr][mm];
        default: a = ea[rr][mm] + 32'd1;
      endcase
      send_req(a, 4'($urandom), 8'($urandom_range(0, 3)),
               $urandom_range(0, 2), 1, 1'b0);
    end

    // Reset during beat 2 of a len-7 DECERR burst
    setup_base();
    @(negedge clk);
    req_addr_i  = 32'h3000_0000;
    req_id_i    = 4'd9;
    req_len_i   = 8'd7;
    req_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    err_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    err_ready_i = 1'b0;
    check("mid_err_valid", err_valid_o, 1);
    check("mid_err_last", err_last_o, 0);
    rst_n = 1'b0;
    #1;
    check("abort_err_valid", err_valid_o, 0);
    check("abort_err_last", err_last_o, 0);
    check("abort_req_ready", req_ready_o, 1);
    check("abort_route_valid", route_valid_o, 0);
`ifdef AXI_DECODE_ERR_CNT_EN
    check("abort_err_cnt", err_cnt_o, 0);
`endif
    exp_err_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    send_req(32'h2000_0000, 4'd1, 8'd0, 0, 2, 1'b0);
    send_req(32'h2000_0004, 4'd2, 8'd1, 0, 0, 1'b0);
    send_req(32'h9000_0000, 4'd3, 8'd2, 0, 1, 1'b0);
`ifdef AXI_DECODE_ERR_CNT_EN
    check("err_cnt_after_3", err_cnt_o, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
